// File: rtl/hazard_controller.sv
// Hazard unit for a five-stage pipeline: operand forwarding, load-use
// interlock, branch flush and a data-memory wait/timeout freeze.
module hazard_controller #(
    parameter logic [7:0]  TIMEOUT = 8'd255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic             ResultSrcD,
    input  logic             MemWriteD,
    input  logic             PCSrcE,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       mw;
    } stage_t;

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

    stage_t     e_q, m_q, w_q;
    stage_t     e_d, m_d, w_d;
    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       req_int;
    logic       freeze;
    logic       lw_stall;
    logic       flush_e_int;

    // Shadow fields that exist only to mirror the datapath registers.
    logic unused_fields;
    assign unused_fields = ^{m_q.rs1, m_q.rs2, w_q.rs1, w_q.rs2, w_q.ld, w_q.mw};

    // Core hazard conditions derived from shadow state and decode inputs.
    always_comb begin
        req_int     = (m_q.ld | m_q.mw) & (state_q != StHalt);
        freeze      = (req_int & ~dmem_ready) | (state_q == StHalt);
        lw_stall    = e_q.ld & (e_q.rd != 5'd0) &
                      ((e_q.rd == Rs1D) | (e_q.rd == Rs2D)) & ~PCSrcE;
        flush_e_int = (lw_stall | PCSrcE) & ~freeze;
    end

    // Forwarding selects; memory stage has priority as it is the younger result.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (m_q.rw && m_q.rd != 5'd0 && m_q.rd == e_q.rs1) begin
                ForwardAE = 2'b10;
            end else if (w_q.rw && w_q.rd != 5'd0 && w_q.rd == e_q.rs1) begin
                ForwardAE = 2'b01;
            end
            if (m_q.rw && m_q.rd != 5'd0 && m_q.rd == e_q.rs2) begin
                ForwardBE = 2'b10;
            end else if (w_q.rw && w_q.rd != 5'd0 && w_q.rd == e_q.rs2) begin
                ForwardBE = 2'b01;
            end
        end
    end

    // Stall/flush outputs; a memory freeze overrides load-use and branch actions.
    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        StallW   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        dmem_req = 1'b0;
        if (!rst) begin
            dmem_req = req_int;
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                StallW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = flush_e_int;
            end
        end
    end

    // Next contents of the shadow pipeline.
    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (!freeze) begin
            if (flush_e_int) begin
                e_d = '0;
            end else begin
                e_d = '{rs1: Rs1D, rs2: Rs2D, rd: RdD,
                        rw: RegWriteD, ld: ResultSrcD, mw: MemWriteD};
            end
            m_d = e_q;
            w_d = m_q;
        end
    end

    // Memory wait FSM and wait-cycle counter.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            StRun: begin
                if (req_int && !dmem_ready) begin
                    state_d = StMemWait;
                    wait_d  = 8'd1;
                end
            end
            StMemWait: begin
                if (dmem_ready) begin
                    state_d = StRun;
                    wait_d  = 8'd0;
                end else if (wait_q == TIMEOUT) begin
                    state_d   = StHalt;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StHalt: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Saturating count of fetch-stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            state_q     <= StRun;
            wait_q      <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scenario bench for hazard_controller: forwarding, load-use, branch flush,
// memory wait, timeout halt and reset recovery.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, ResultSrcD, MemWriteD;
    logic        PCSrcE, dmem_ready;
    logic        StallF, StallD, StallE, StallM, StallW;
    logic        FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        dmem_req, mem_err;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [12:0] outs;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] LWS  = 5'b11000;
    localparam logic [4:0] ALL  = 5'b11111;

    hazard_controller #(
        .TIMEOUT(8'd4),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdD       (RdD),
        .RegWriteD (RegWriteD),
        .ResultSrcD(ResultSrcD),
        .MemWriteD (MemWriteD),
        .PCSrcE    (PCSrcE),
        .dmem_ready(dmem_ready),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .StallW    (StallW),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .dmem_req  (dmem_req),
        .mem_err   (mem_err),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] ev(input logic [4:0] st, input logic fd, input logic fe,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic req, input logic err);
        return {st, fd, fe, fa, fb, req, err};
    endfunction

    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic mw);
        Rs1D       = rs1;
        Rs2D       = rs2;
        RdD        = rd;
        RegWriteD  = rw;
        ResultSrcD = ld;
        MemWriteD  = mw;
    endtask

    // Push the expectation for the currently driven inputs, compare mid-cycle.
    task automatic step(input string tag, input logic [12:0] outs, input int cnt);
        exp_t e;
        exp_t got;
        e.tag  = tag;
        e.outs = outs;
        e.cnt  = 16'(cnt);
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check_eq({got.tag, "_outs"},
                 {19'd0, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
                  ForwardAE, ForwardBE, dmem_req, mem_err}, {19'd0, got.outs});
        check_eq({got.tag, "_cnt"}, {16'd0, stall_cnt}, {16'd0, got.cnt});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        PCSrcE     = 1'b1;
        dmem_ready = 1'b1;
        set_d(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        step("reset", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        rst    = 1'b0;
        PCSrcE = 1'b0;

        // Back-to-back add x5 / sub x8,x5,x3.
        set_d(5'd1, 5'd2, 5'd5, 1, 0, 0); step("c1_add", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        set_d(5'd5, 5'd3, 5'd8, 1, 0, 0); step("c2_sub", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        set_d(5'd0, 5'd0, 5'd0, 0, 0, 0); step("c3_fwdM", ev(NONE, 0, 0, 2'b10, 2'b00, 0, 0), 0);
        step("c4_nop", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        // One gap: sub x9,x5,x5 gets the writeback result on both operands.
        set_d(5'd1, 5'd2, 5'd5, 1, 0, 0); step("c5_add", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        set_d(5'd0, 5'd0, 5'd0, 0, 0, 0); step("c6_gap", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        set_d(5'd5, 5'd5, 5'd9, 1, 0, 0); step("c7_sub", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        set_d(5'd0, 5'd0, 5'd0, 0, 0, 0); step("c8_fwdW", ev(NONE, 0, 0, 2'b01, 2'b01, 0, 0), 0);
        step("c9_nop", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);

        // Load-use: lw x6 then add x7,x6,x1.
        set_d(5'd1, 5'd0, 5'd6, 1, 1, 0); step("c10_lw", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        set_d(5'd6, 5'd1, 5'd7, 1, 0, 0); step("c11_luse", ev(LWS, 0, 1, 2'b00, 2'b00, 0, 0), 0);
        step("c12_held", ev(NONE, 0, 0, 2'b00, 2'b00, 1, 0), 1);
        set_d(5'd0, 5'd0, 5'd0, 0, 0, 0); step("c13_fwd", ev(NONE, 0, 0, 2'b01, 2'b00, 0, 0), 1);

        // Taken branch with a load-use match in the same cycle.
        set_d(5'd2, 5'd0, 5'd10, 1, 1, 0); step("c14_lw", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 1);
        set_d(5'd10, 5'd4, 5'd12, 1, 0, 0);
        PCSrcE = 1'b1;
        step("c15_br", ev(NONE, 1, 1, 2'b00, 2'b00, 0, 0), 1);
        PCSrcE = 1'b0;
        set_d(5'd0, 5'd0, 5'd0, 0, 0, 0); step("c16_post", ev(NONE, 0, 0, 2'b00, 2'b00, 1, 0), 1);

        // Store waits three cycles on memory.
        set_d(5'd1, 5'd2, 5'd0, 0, 0, 1); step("c17_sw", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 1);
        set_d(5'd0, 5'd0, 5'd0, 0, 0, 0); step("c18_nop", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 1);
        dmem_ready = 1'b0;
        step("c19_wait1", ev(ALL, 0, 0, 2'b00, 2'b00, 1, 0), 1);
        PCSrcE = 1'b1;
        step("c20_wait2", ev(ALL, 0, 0, 2'b00, 2'b00, 1, 0), 2);
        PCSrcE = 1'b0;
        step("c21_wait3", ev(ALL, 0, 0, 2'b00, 2'b00, 1, 0), 3);
        dmem_ready = 1'b1;
        step("c22_adv", ev(NONE, 0, 0, 2'b00, 2'b00, 1, 0), 4);
        dmem_ready = 1'b0;
        step("c23_run", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 4);

        // Load that never completes: timeout into HALT.
        dmem_ready = 1'b1;
        set_d(5'd0, 5'd0, 5'd11, 1, 1, 0); step("c24_lw", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 4);
        set_d(5'd0, 5'd0, 5'd0, 0, 0, 0); step("c25_nop", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 4);
        dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("to_wait%0d", i), ev(ALL, 0, 0, 2'b00, 2'b00, 1, 0), 4 + i);
        end
        step("halt1", ev(ALL, 0, 0, 2'b00, 2'b00, 0, 1), 9);
        dmem_ready = 1'b1;
        step("halt2", ev(ALL, 0, 0, 2'b00, 2'b00, 0, 1), 10);

        // Reset out of HALT.
        rst        = 1'b1;
        PCSrcE     = 1'b1;
        dmem_ready = 1'b0;
        set_d(5'd3, 5'd3, 5'd3, 1, 1, 0);
        step("rst_halt", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        rst    = 1'b0;
        PCSrcE = 1'b0;

        // Load to x0 followed by a use of x0.
        set_d(5'd1, 5'd0, 5'd0, 1, 1, 0); step("c34_lwx0", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        dmem_ready = 1'b1;
        set_d(5'd0, 5'd0, 5'd3, 1, 0, 0); step("c35_usex0", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);
        set_d(5'd0, 5'd0, 5'd0, 0, 0, 0); step("c36_x0fwd", ev(NONE, 0, 0, 2'b00, 2'b00, 1, 0), 0);
        step("c37_x0w", ev(NONE, 0, 0, 2'b00, 2'b00, 0, 0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255, max cycles waiting on dmem_ready before halt.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall_cnt.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports Rs1D, Rs2D, RdD  in  5 each  decode-stage source/destination register numbers.
REQ-006 SHALL have ports RegWriteD, ResultSrcD, MemWriteD  in  1 each  decode-stage control (ResultSrcD=1 means load).
REQ-007 SHALL have port PCSrcE  in  1  branch/jump taken, resolved in execute.
REQ-008 SHALL have port dmem_ready  in  1  data memory completes current access this cycle.
REQ-009 SHALL have ports StallF, StallD, StallE, StallM, StallW  out  1 each  hold stage register.
REQ-010 SHALL have ports FlushD, FlushE  out  1 each  bubble stage register.
REQ-011 SHALL have ports ForwardAE, ForwardBE  out  2 each  00 regfile, 01 writeback result, 10 memory ALU result.
REQ-012 SHALL have port dmem_req  out  1  memory-stage access pending.
REQ-013 SHALL have ports mem_err  out  1 sticky timeout flag; stall_cnt  out  CNT_W  cycles with StallF=1.

Function
REQ-014 SHALL keep shadow stages E, M, W each holding rs1, rs2, rd, rw, ld, mw mirroring the datapath pipeline registers.
REQ-015 SHALL, when not frozen, load E from decode fields (or bubble if FlushE), M from E, W from M each rising edge; bubble = all fields zero.
REQ-016 SHALL, when frozen, hold E, M, W unchanged.
REQ-017 SHALL set ForwardAE=10 if M.rw, M.rd!=0, M.rd==E.rs1; else 01 if W.rw, W.rd!=0, W.rd==E.rs1; else 00; ForwardBE identically with E.rs2.
REQ-018 SHALL compute lwStall = E.ld & E.rd!=0 & (E.rd==Rs1D | E.rd==Rs2D) & !PCSrcE.
REQ-019 SHALL, not frozen: StallF=StallD=lwStall, FlushD=PCSrcE, FlushE=lwStall|PCSrcE, StallE=StallM=StallW=0.
REQ-020 SHALL drive dmem_req = (M.ld|M.mw) in RUN and MEM_WAIT, 0 in HALT.
REQ-021 SHALL define freeze = (dmem_req & !dmem_ready) | state==HALT, combinational.
REQ-022 SHALL, frozen: all five Stall outputs 1, FlushD=FlushE=0; freeze overrides lwStall and PCSrcE.
REQ-023 SHALL implement FSM states RUN, MEM_WAIT, HALT.
REQ-024 RUN -> MEM_WAIT when dmem_req & !dmem_ready; wait counter loaded 1.
REQ-025 MEM_WAIT -> RUN when dmem_ready (pipeline advances that same cycle); else counter+1.
REQ-026 MEM_WAIT -> HALT when counter==TIMEOUT and !dmem_ready; mem_err set to 1.
REQ-027 SHALL remain in HALT, with mem_err=1, until reset.
REQ-028 SHALL increment stall_cnt each cycle StallF=1, saturating at all-ones.
REQ-029 SHALL produce forwarding and stall/flush outputs combinationally from shadow state and current inputs (zero-cycle latency).

Reset
REQ-030 SHALL, on rst=1, immediately clear all shadow stages to bubble, state=RUN, wait counter=0, stall_cnt=0, mem_err=0.
REQ-031 SHALL, during reset, drive all Stall/Flush=0, Forward=00, dmem_req=0.
REQ-032 SHALL, on reset asserted mid-MEM_WAIT or in HALT, abandon the access and return to RUN without waiting for dmem_ready.

Verification
REQ-033 add x5 then sub using x5 back-to-back -> ForwardAE=10 in sub's E cycle; with one gap instruction -> 01.
REQ-034 lw x6 then add x7,x6,x1 -> one cycle StallF=StallD=FlushE=1, then ForwardAE=01; stall_cnt=1.
REQ-035 taken branch (PCSrcE=1) -> FlushD=FlushE=1 one cycle, no stall; load-use match same cycle suppressed.
REQ-036 sw in M with dmem_ready low 3 cycles -> all Stall=1 for 3 cycles, dmem_req held, advance on 4th; state RUN afterwards.
REQ-037 TIMEOUT=4, dmem_ready never high -> HALT after 4 wait cycles, mem_err=1, dmem_req=0, stalls stay 1; rst then clears all.
REQ-038 rd=x0 load followed by use of x0 -> no stall, forwards stay 00.
